// File: rtl/tb_vperiph_pkg.sv
// tb_vperiph_pkg: register offsets, pass magic default and register-select decode
// shared by the virtual peripheral and its testbench.
package tb_vperiph_pkg;

    localparam logic [7:0] OFS_PRINT  = 8'h00;
    localparam logic [7:0] OFS_STATUS = 8'h04;
    localparam logic [7:0] OFS_EXIT   = 8'h08;
    localparam logic [7:0] OFS_TCMP   = 8'h0C;
    localparam logic [7:0] OFS_TVAL   = 8'h10;
    localparam logic [7:0] OFS_ACK    = 8'h14;
    localparam logic [7:0] OFS_CYCLE  = 8'h18;

    localparam logic [31:0] PASS_MAGIC_DEF = 32'd123456789;

    typedef enum logic [2:0] {
        SEL_PRINT, SEL_STATUS, SEL_EXIT, SEL_TCMP, SEL_TVAL, SEL_ACK, SEL_CYCLE, SEL_NONE
    } reg_sel_e;

    function automatic reg_sel_e decode_sel(input logic [7:0] ofs);
        return ofs == OFS_PRINT  ? SEL_PRINT  :
               ofs == OFS_STATUS ? SEL_STATUS :
               ofs == OFS_EXIT   ? SEL_EXIT   :
               ofs == OFS_TCMP   ? SEL_TCMP   :
               ofs == OFS_TVAL   ? SEL_TVAL   :
               ofs == OFS_ACK    ? SEL_ACK    :
               ofs == OFS_CYCLE  ? SEL_CYCLE  : SEL_NONE;
    endfunction

endpackage

// File: rtl/tb_vperiph_if.sv
// tb_vperiph_if: OBI-style data bus (req/gnt/rvalid, addr, we, be, wdata, rdata).
// master drives the request side, slave drives gnt/rvalid/rdata.
interface tb_vperiph_if;
    logic        req;
    logic        gnt;
    logic        rvalid;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/tb_vperiph_fifo.sv
// tb_vperiph_fifo: synchronous FIFO for the stdout path (used with TB_VPERIPH_STDOUT_FIFO_EN).
// Ports: clk_i, rst_ni (async low), push_i/data_i, pop_i, full_o, empty_o, data_o (head, 0 when empty).
// A push while full is accepted when a pop happens in the same cycle.
module tb_vperiph_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] data_o
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_cnt;
    logic          w_push, w_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
    endfunction

    assign empty_o = r_cnt == '0;
    assign full_o  = r_cnt == CW'(DEPTH);
    assign w_pop   = pop_i && !empty_o;
    assign w_push  = push_i && (!full_o || w_pop);
    assign data_o  = empty_o ? '0 : r_mem[r_rp];

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wp] <= data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= nxt(r_wp);
            if (w_pop) r_rp <= nxt(r_rp);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: rtl/tb_virtual_periph.sv
// tb_virtual_periph: memory-mapped test peripheral (status, exit, stdout, timer, cycle counter).
// Ports: clk_i, rst_ni (async low), bus (tb_vperiph_if.slave), tests_passed_o, tests_failed_o,
//        exit_valid_o, exit_value_o, timer_irq_o, stdout_valid_o, stdout_char_o, stdout_ready_i.
// Build option: TB_VPERIPH_STDOUT_FIFO_EN selects a FIFO_DEPTH-entry stdout FIFO instead of
// a single holding register.
module tb_virtual_periph
    import tb_vperiph_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] PASS_MAGIC = PASS_MAGIC_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    tb_vperiph_if.slave bus,
    output logic        tests_passed_o,
    output logic        tests_failed_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o,
    output logic        timer_irq_o,
    output logic        stdout_valid_o,
    output logic [7:0]  stdout_char_o,
    input  logic        stdout_ready_i
);
    reg_sel_e    w_sel;
    logic        w_full, w_xfer, w_word, w_push;
    logic [31:0] w_rdata;
    logic [31:0] r_tcmp, r_tval, r_cycle;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end

    assign w_sel   = bus.addr[31:8] == BASE_ADDR[31:8] ? decode_sel(bus.addr[7:0]) : SEL_NONE;
    // Only a PRINT write into a full stdout buffer is stalled; the core keeps req high.
    assign bus.gnt = bus.req && !(bus.we && w_sel == SEL_PRINT && w_full);
    assign w_xfer  = bus.req && bus.gnt;
    assign w_word  = w_xfer && bus.we && bus.be == 4'hF;
    assign w_push  = w_xfer && bus.we && w_sel == SEL_PRINT && bus.be[0];
    assign w_rdata = w_sel == SEL_TCMP  ? r_tcmp  :
                     w_sel == SEL_TVAL  ? r_tval  :
                     w_sel == SEL_CYCLE ? r_cycle : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.rvalid     <= 1'b0;
            bus.rdata      <= '0;
            tests_passed_o <= 1'b0;
            tests_failed_o <= 1'b0;
            exit_valid_o   <= 1'b0;
            exit_value_o   <= '0;
            timer_irq_o    <= 1'b0;
            r_tcmp         <= '0;
            r_tval         <= '0;
            r_cycle        <= '0;
        end else begin
            bus.rvalid <= w_xfer;
            bus.rdata  <= w_xfer && !bus.we ? w_rdata : '0;
            r_cycle    <= r_cycle + 32'd1;
            if (w_word && w_sel == SEL_STATUS && !tests_passed_o && !tests_failed_o) begin
                tests_passed_o <= bus.wdata == PASS_MAGIC;
                tests_failed_o <= bus.wdata != PASS_MAGIC;
            end
            if (w_word && w_sel == SEL_EXIT && !exit_valid_o) begin
                exit_valid_o <= 1'b1;
                exit_value_o <= bus.wdata;
            end
            if (w_word && w_sel == SEL_TCMP) begin
                r_tcmp      <= bus.wdata;
                r_tval      <= bus.wdata;
                timer_irq_o <= 1'b0;
            end else begin
                if (r_tval != '0) r_tval <= r_tval - 32'd1;
                if (w_word && w_sel == SEL_ACK) timer_irq_o <= 1'b0;
                // Expiry in the same cycle as an ack still raises the irq.
                if (r_tval == 32'd1) timer_irq_o <= 1'b1;
            end
        end
    end

`ifdef TB_VPERIPH_STDOUT_FIFO_EN
    logic w_empty, w_fifo_full;

    tb_vperiph_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .data_i  (bus.wdata[7:0]),
        .pop_i   (stdout_ready_i),
        .full_o  (w_fifo_full),
        .empty_o (w_empty),
        .data_o  (stdout_char_o)
    );

    assign stdout_valid_o = !w_empty;
    assign w_full         = w_fifo_full && !stdout_ready_i;
`else
    // A draining holding register can accept a new character in the same cycle.
    assign w_full = stdout_valid_o && !stdout_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stdout_valid_o <= 1'b0;
            stdout_char_o  <= '0;
        end else if (w_push) begin
            stdout_valid_o <= 1'b1;
            stdout_char_o  <= bus.wdata[7:0];
        end else if (stdout_ready_i) begin
            stdout_valid_o <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_tb_virtual_periph.sv
// tb_tb_virtual_periph: randomized scoreboard bench for tb_virtual_periph with a
// time-based reference model of the status, exit, timer, cycle and stdout behaviour.
module tb_tb_virtual_periph;
    localparam logic [31:0] BASE  = 32'h2000_0000;
    localparam logic [31:0] MAGIC = 32'd123456789;
    localparam int          DEPTH = 4;
`ifdef TB_VPERIPH_STDOUT_FIFO_EN
    localparam int CAP = DEPTH;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ready = 1'b0;
    logic        passed, failed, exit_v, irq, so_valid;
    logic [31:0] exit_val;
    logic [7:0]  so_char;
    bit          rand_ready = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    longint      cyc = 0;

    tb_vperiph_if bus ();

    tb_virtual_periph #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .PASS_MAGIC(MAGIC)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .bus            (bus),
        .tests_passed_o (passed),
        .tests_failed_o (failed),
        .exit_valid_o   (exit_v),
        .exit_value_o   (exit_val),
        .timer_irq_o    (irq),
        .stdout_valid_o (so_valid),
        .stdout_char_o  (so_char),
        .stdout_ready_i (ready)
    );

    always #5 clk = ~clk;

    // Number of clock edges seen since reset was released.
    always @(posedge clk or negedge rst_n) cyc <= !rst_n ? 0 : cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: timer described by load edge E, load value V and first effective ack edge.
    bit          m_pass, m_fail, m_exit;
    logic [31:0] m_exit_val, m_tcmp;
    longint      m_te, m_tv, m_ack;
    logic [31:0] rq[$];
    logic [7:0]  cq[$];
    bit          exp_rv, exp_gnt, full, word;
    logic [7:0]  ofs;

    function automatic logic [31:0] tval(input longint n);
        return m_tv > n - m_te ? 32'(m_tv - (n - m_te)) : 32'd0;
    endfunction

    function automatic bit tirq(input longint n);
        return m_tv != 0 && n >= m_te + m_tv && (m_ack <= m_te + m_tv || n < m_ack);
    endfunction

    task automatic model_reset();
        m_pass = 0; m_fail = 0; m_exit = 0; m_exit_val = '0; m_tcmp = '0;
        m_te = 0; m_tv = 0; m_ack = 0; exp_rv = 0;
        rq.delete(); cq.delete();
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_rvalid", bus.rvalid, 0);
                chk("rst_flags", {passed, failed, exit_v, irq, so_valid}, 0);
                chk("rst_exit_value", exit_val, 0);
                model_reset();
            end else begin
                chk("rvalid", bus.rvalid, exp_rv);
                if (exp_rv) chk("rdata", bus.rdata, rq.pop_front());
                chk("tests_passed", passed, m_pass);
                chk("tests_failed", failed, m_fail);
                chk("exit_valid", exit_v, m_exit);
                chk("exit_value", exit_val, m_exit_val);
                chk("timer_irq", irq, tirq(cyc));
                chk("stdout_valid", so_valid, cq.size() != 0);
                full = cq.size() == CAP && !ready;
                exp_gnt = bus.req && !(bus.we && bus.addr == BASE && full);
                chk("gnt", bus.gnt, exp_gnt);
                if (cq.size() != 0) begin
                    chk("stdout_char", so_char, cq[0]);
                    if (ready) void'(cq.pop_front());
                end
                exp_rv = 0;
                if (bus.req && bus.gnt) begin
                    exp_rv = 1;
                    ofs = bus.addr[31:8] == BASE[31:8] ? bus.addr[7:0] : 8'hFF;
                    word = bus.we && bus.be == 4'hF;
                    rq.push_back(bus.we ? 32'd0 : ofs == 8'h0C ? m_tcmp : ofs == 8'h10 ? tval(cyc) :
                                 ofs == 8'h18 ? cyc[31:0] : 32'd0);
                    if (bus.we && ofs == 8'h00 && bus.be[0]) cq.push_back(bus.wdata[7:0]);
                    if (word && ofs == 8'h04 && !m_pass && !m_fail) begin
                        if (bus.wdata == MAGIC) m_pass = 1;
                        else m_fail = 1;
                    end
                    if (word && ofs == 8'h08 && !m_exit) begin
                        m_exit = 1;
                        m_exit_val = bus.wdata;
                    end
                    if (word && ofs == 8'h0C) begin
                        m_tcmp = bus.wdata; m_tv = longint'(bus.wdata); m_te = cyc + 1; m_ack = 0;
                    end
                    if (word && ofs == 8'h14 && m_ack <= m_te + m_tv) m_ack = cyc + 1;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            if (rand_ready) ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic xfer(input logic [7:0] o, input logic we, input logic [3:0] be, input logic [31:0] wd);
        bit done = 0;
        bus.req = 1; bus.addr = BASE + {24'd0, o}; bus.we = we; bus.be = be; bus.wdata = wd;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            done = bus.gnt;
            @(posedge clk); #1;
            if (rand_ready) ready = 1'($urandom_range(0, 1));
        end
        bus.req = 0; bus.we = 0; bus.be = '0; bus.wdata = '0;
        chk("gnt_wait", done, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    logic [7:0] offs[9] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h40};

    initial begin
        bus.req = 0; bus.addr = '0; bus.we = 0; bus.be = '0; bus.wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        ready = 1;
        idle(2);
        xfer(8'h18, 0, 4'hF, 0);
        xfer(8'h04, 1, 4'hF, MAGIC);
        xfer(8'h04, 1, 4'hF, 32'd1);
        xfer(8'h40, 0, 4'hF, 0);
        xfer(8'h40, 1, 4'hF, 32'hDEAD_BEEF);
        xfer(8'h08, 1, 4'h3, 32'd7);
        idle(1);
        xfer(8'h08, 1, 4'hF, 32'h2A);
        xfer(8'h08, 1, 4'hF, 32'd0);
        xfer(8'h0C, 1, 4'hF, 32'd5);
        xfer(8'h10, 0, 4'hF, 0);
        xfer(8'h10, 0, 4'hF, 0);
        xfer(8'h10, 0, 4'hF, 0);
        idle(4);
        xfer(8'h14, 1, 4'hF, 0);
        xfer(8'h0C, 0, 4'hF, 0);
        xfer(8'h0C, 1, 4'hF, 32'd5);
        repeat (4) @(posedge clk);
        #1;
        xfer(8'h0C, 1, 4'hF, 32'd7);
        idle(10);
        xfer(8'h14, 1, 4'hF, 0);
        ready = 0;
        fork
            for (int i = 0; i <= CAP; i++) xfer(8'h00, 1, 4'h1, 32'h41 + i);
            begin
                repeat (CAP + 6) @(posedge clk);
                #1 ready = 1;
            end
        join
        idle(CAP + 3);
        rand_ready = 1;
        for (int i = 0; i < 300; i++) begin
            automatic logic [7:0] o = offs[$urandom_range(0, 8)];
            automatic logic [3:0] be = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'hF;
            automatic logic [31:0] wd = o == 8'h0C ? $urandom_range(0, 20) : $urandom;
            xfer(o, 1'($urandom_range(0, 1)), be, wd);
            idle($urandom_range(0, 3));
        end
        rand_ready = 0;
        ready = 1;
        idle(DEPTH + 25);
        bus.req = 1; bus.addr = BASE + 32'h18; bus.we = 0; bus.be = 4'hF;
        @(negedge clk);
        chk("rst_mid_gnt", bus.gnt, 1);
        #1 rst_n = 0;
        bus.req = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        idle(3);
        xfer(8'h18, 0, 4'hF, 0);
        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
